gost89_ecb_stream_ctrl: RTL and testbench

GOST89_ECB_STREAM_CTRL -- requirements
Module: gost89_ecb_stream_ctrl

---
 rtl/gost89_ecb_stream_ctrl.sv | 159 +++++++++++++++
 tb/tb_gost89_ecb_stream_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gost89_ecb_stream_ctrl.sv
// Streaming wrapper around a gost89_ecb core: one block in flight, 2-entry result FIFO,
// watchdog on the core and a synchronous flush. Handshake: a transfer happens on a rising edge where valid&ready.
module gost89_ecb_stream_ctrl #(
    parameter int MAX_CYCLES = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_mode,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        core_load,
    output logic        core_mode,
    output logic [63:0] core_in,
    output logic        core_reset,
    input  logic [63:0] core_out,
    input  logic        core_busy,
    output logic [15:0] blk_count,
    output logic        error,
    output logic [1:0]  dbg_state
);

    localparam int WDW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_RUN} state_t;

    state_t      r_state, w_next_state;
    logic [1:0]  r_rst_sync;
    logic        r_mode;
    logic [63:0] r_core_in;
    logic        r_core_reset;
    logic [15:0] r_blk_count;
    logic        r_error;
    logic [WDW-1:0] r_wd;
    logic [63:0] r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic w_accept, w_push, w_pop, w_timeout, w_in_ready, w_core_load, w_wd_hit;

    // Release of reset is re-timed so nothing is accepted on the release edge itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    assign w_wd_hit = (r_wd >= WDW'(MAX_CYCLES - 1));

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_push       = 1'b0;
        w_timeout    = 1'b0;
        w_in_ready   = 1'b0;
        w_core_load  = 1'b0;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // count <= 1 leaves a free slot for the result of the block about to start
                    w_in_ready = r_rst_sync[1] && (r_count <= 2'd1);
                    if (w_in_ready && in_valid) begin
                        w_accept     = 1'b1;
                        w_next_state = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_core_load  = 1'b1;
                    w_next_state = S_START;
                end
                S_START: begin
                    if (w_wd_hit) begin
                        w_timeout    = 1'b1;
                        w_next_state = S_IDLE;
                    end else if (core_busy) begin
                        w_next_state = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!core_busy) begin
                        w_push       = 1'b1;
                        w_next_state = S_IDLE;
                    end else if (w_wd_hit) begin
                        w_timeout    = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    assign w_pop = (r_count != 2'd0) && out_ready && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode       <= 1'b0;
            r_core_in    <= 64'd0;
            r_core_reset <= 1'b0;
            r_blk_count  <= 16'd0;
            r_error      <= 1'b0;
            r_wd         <= '0;
            r_mem[0]     <= 64'd0;
            r_mem[1]     <= 64'd0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
        end else begin
            r_core_reset <= abort | w_timeout;
            if (w_accept) begin
                r_core_in <= in_data;
                r_mode    <= in_mode;
            end
            if (w_accept)                           r_wd <= '0;
            else if (r_state != S_IDLE && !abort)   r_wd <= r_wd + 1'b1;
            if (w_timeout) r_error <= 1'b1;
            if (w_push)    r_blk_count <= r_blk_count + 16'd1;
            if (abort) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= core_out;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                if (w_pop) r_rd_ptr <= ~r_rd_ptr;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = (r_count != 2'd0);
    assign out_data   = r_mem[r_rd_ptr];
    assign core_load  = w_core_load;
    assign core_mode  = r_mode;
    assign core_in    = r_core_in;
    assign core_reset = r_core_reset;
    assign blk_count  = r_blk_count;
    assign error      = r_error;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_gost89_ecb_stream_ctrl.sv
// Bench for gost89_ecb_stream_ctrl with a behavioural core stub (configurable latency or dead)
// and a reference model: expected result queue, block counter and sticky error flag.
module tb_gost89_ecb_stream_ctrl;

    localparam int MAXC = 48;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_mode = 1'b0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        core_load, core_mode, core_reset;
    logic [63:0] core_in;
    logic [63:0] core_out;
    logic        core_busy;
    logic [15:0] blk_count;
    logic        error;
    logic [1:0]  dbg_state;

    gost89_ecb_stream_ctrl #(.MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .core_load(core_load),
        .core_mode(core_mode), .core_in(core_in), .core_reset(core_reset),
        .core_out(core_out), .core_busy(core_busy), .blk_count(blk_count),
        .error(error), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- core stub ----------------
    function automatic logic [63:0] ref_cipher(input logic [63:0] x, input logic m);
        return m ? ({x[15:0], x[63:16]} ^ 64'h0123_4567_89ab_cdef)
                 : ({x[31:0], x[63:32]} ^ 64'hfedc_ba98_7654_3210);
    endfunction

    int          stub_lat = 4;
    bit          stub_dead = 1'b0;
    int          stub_cnt = 0;
    logic        stub_busy = 1'b0;
    logic [63:0] stub_res = '0;

    always @(posedge clk) begin
        if (core_reset) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
        end else if (core_load && !stub_dead) begin
            stub_busy <= 1'b1;
            stub_cnt  <= stub_lat;
            stub_res  <= ref_cipher(core_in, core_mode);
        end else if (stub_busy) begin
            if (stub_cnt <= 1) stub_busy <= 1'b0;
            stub_cnt <= stub_cnt - 1;
        end
    end
    assign core_busy = stub_busy;
    assign core_out  = stub_res;

    // ---------------- model / scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [15:0] model_blk = '0;
    logic        model_error = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          rnd_ready = 1'b0;

    always @(negedge clk) begin
        if (reset && out_valid && out_ready && !abort) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output: got %h, want no output", out_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) $display("FAIL out_data: got %h want %h", out_data, e);
                else n_pass++;
            end
        end
        if (reset && dut.w_push && dut.r_count == 2'd2) begin
            n_checks++;
            $display("FAIL fifo_overflow: push with count=%0d, want count<2", dut.r_count);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [63:0] d, input logic m, input bit expect_result);
        int waited = 0;
        while (!in_ready && waited < 300) begin tick(); waited++; end
        n_checks++;
        if (!in_ready) begin
            $display("FAIL accept_wait: in_ready=%b after %0d cycles, want 1", in_ready, waited);
        end else begin
            n_pass++;
            in_valid = 1'b1; in_data = d; in_mode = m;
            if (expect_result) begin
                exp_q.push_back(ref_cipher(d, m));
                model_blk++;
            end
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin tick(); w++; end
        tick();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (blk_count !== model_blk) $display("FAIL blk_count: got %h want %h", blk_count, model_blk);
        else n_pass++;
    endtask

    task automatic wait_blk();
        int w = 0;
        while (blk_count !== model_blk && w < 300) begin tick(); w++; end
        n_checks++;
        if (blk_count !== model_blk) $display("FAIL wait_blk: got %h want %h", blk_count, model_blk);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        n_checks++;
        if ({in_ready, out_valid, out_data, core_load, core_reset, core_mode, core_in, blk_count, error} !== '0)
            $display("FAIL reset_outputs: got rdy=%b ov=%b od=%h ld=%b cr=%b cm=%b ci=%h bc=%h er=%b, want all 0",
                     in_ready, out_valid, out_data, core_load, core_reset, core_mode, core_in, blk_count, error);
        else n_pass++;
        tick(); tick();
        reset = 1'b1;
        in_valid = 1'b1; in_data = 64'h1111_2222_3333_4444;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL release_ready0: got %b want 0", in_ready); else n_pass++;
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL release_ready1: in_ready=%b state=%0d, want 0/0", in_ready, dbg_state);
        else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_single(input logic m);
        logic [63:0] d;
        int lat;
        d = {$urandom(), $urandom()};
        stub_lat = $urandom_range(2, 8);
        out_ready = 1'b1;
        send(d, m, 1'b1);
        n_checks++;
        if (core_load !== 1'b1 || core_in !== d || core_mode !== m)
            $display("FAIL load_cycle: ld=%b ci=%h cm=%b, want 1/%h/%b", core_load, core_in, core_mode, d, m);
        else n_pass++;
        tick();
        lat = 2;
        n_checks++;
        if (core_load !== 1'b0) $display("FAIL load_pulse: core_load=%b want 0", core_load); else n_pass++;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        n_checks++;
        if (lat != stub_lat + 3) $display("FAIL latency: got %0d want %0d", lat, stub_lat + 3);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        rnd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            stub_lat = $urandom_range(2, 8);
            send({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'b1);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        stub_lat = 5;
        send(64'h389e_b44a_3914_74c4, 1'b0, 1'b1);
        send(64'hc354_72c9_1cd7_8640, 1'b1, 1'b1);
        wait_blk();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL full_backpressure: in_ready=%b out_valid=%b, want 0/1", in_ready, out_valid);
        else n_pass++;
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_abort();
        logic [15:0] blk_before;
        out_ready = 1'b1;
        stub_lat = 10;
        blk_before = model_blk;
        send(64'h0123_4567_89ab_cdef, 1'b0, 1'b0);
        repeat (5) tick();
        abort = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", in_ready); else n_pass++;
        tick();
        abort = 1'b0;
        n_checks++;
        if (core_reset !== 1'b1 || dbg_state !== 2'd0)
            $display("FAIL abort_pulse: core_reset=%b state=%0d, want 1/0", core_reset, dbg_state);
        else n_pass++;
        tick();
        n_checks++;
        if (core_reset !== 1'b0) $display("FAIL abort_pulse_end: got %b want 0", core_reset); else n_pass++;
        repeat (20) tick();
        n_checks++;
        if (blk_count !== blk_before || error !== model_error)
            $display("FAIL abort_counters: bc=%h er=%b, want %h/%b", blk_count, error, blk_before, model_error);
        else n_pass++;
        stub_lat = 4;
        send(64'h3f38_ae3b_8f54_1361, 1'b0, 1'b1);
        drain();
        // flush with a result parked in the FIFO
        out_ready = 1'b0;
        send({$urandom(), $urandom()}, 1'b1, 1'b1);
        wait_blk();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        n_checks++;
        if (out_valid !== 1'b0 || blk_count !== model_blk)
            $display("FAIL abort_flush: out_valid=%b bc=%h, want 0/%h", out_valid, blk_count, model_blk);
        else n_pass++;
        out_ready = 1'b1;
    endtask

    task automatic test_watchdog();
        int k = 0;
        out_ready = 1'b1;
        stub_dead = 1'b1;
        send({$urandom(), $urandom()}, 1'b0, 1'b0);
        while (!core_reset && k < 200) begin tick(); k++; end
        n_checks++;
        if (k != MAXC) $display("FAIL watchdog_time: got %0d want %0d", k, MAXC); else n_pass++;
        model_error = 1'b1;
        n_checks++;
        if (error !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL watchdog_state: er=%b ov=%b rdy=%b, want 1/0/1", error, out_valid, in_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (core_reset !== 1'b0) $display("FAIL watchdog_pulse: got %b want 0", core_reset); else n_pass++;
        stub_dead = 1'b0;
        stub_lat = 3;
        send({$urandom(), $urandom()}, 1'b1, 1'b1);
        drain();
        n_checks++;
        if (error !== model_error) $display("FAIL error_sticky: got %b want %b", error, model_error);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        stub_lat = 10;
        send({$urandom(), $urandom()}, 1'b0, 1'b1);
        wait_blk();
        send({$urandom(), $urandom()}, 1'b0, 1'b0);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_data, core_load, core_reset, core_mode, core_in, blk_count, error} !== '0)
            $display("FAIL async_reset: rdy=%b ov=%b od=%h ld=%b cr=%b cm=%b ci=%h bc=%h er=%b, want all 0",
                     in_ready, out_valid, out_data, core_load, core_reset, core_mode, core_in, blk_count, error);
        else n_pass++;
        exp_q.delete();
        model_blk = '0;
        model_error = 1'b0;
        tick(); tick();
        reset = 1'b1;
        out_ready = 1'b1;
        stub_lat = 4;
        send(64'h3b58_34a0_00fb_a066, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        stub_lat = 2;
        force dut.r_blk_count = 16'hFFFF;
        tick();
        release dut.r_blk_count;
        model_blk = 16'hFFFF;
        send({$urandom(), $urandom()}, 1'b0, 1'b1);
        drain();
        n_checks++;
        if (blk_count !== 16'h0000) $display("FAIL blk_wrap: got %h want 0000", blk_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single(1'b0);
        test_single(1'b1);
        test_single(1'($urandom_range(0, 1)));
        test_random();
        test_back_to_back();
        test_abort();
        test_watchdog();
        test_reset_mid();
        test_wrap();
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
